// File: rtl/cpack_pkg.sv
// Shared constants and types for the compression dictionary and the pattern comparators.
package cpack_pkg;

    localparam int unsigned CPACK_WIDTH = 32;
    localparam int unsigned CPACK_WORDS = 16;
    localparam int unsigned CPACK_IDX_W = $clog2(CPACK_WORDS);
    localparam int unsigned CPACK_CNT_W = 16;

    typedef logic [CPACK_WIDTH-1:0] dict_word_t;
    typedef logic [CPACK_IDX_W-1:0] dict_idx_t;

endpackage

// File: rtl/cpack_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones once reached.
module cpack_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cpack_dictionary.sv
// 16-entry FIFO-replacement word dictionary feeding the pattern comparators.
// Optional statistics counters are built when CPACK_DICT_STATS_EN is defined.
module cpack_dictionary
    import cpack_pkg::*;
#(
    parameter int unsigned WIDTH = CPACK_WIDTH,
    parameter int unsigned WORDS = CPACK_WORDS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_word_i,
    input  logic [$clog2(WORDS)-1:0]   rd_idx_i,
    output logic [WORDS*WIDTH-1:0]     dictionary_o,
    output logic [WORDS-1:0]           valid_mask_o,
    output logic [$clog2(WORDS)-1:0]   wr_ptr_o,
    output logic                       full_o,
    output logic [WIDTH-1:0]           rd_word_o
`ifdef CPACK_DICT_STATS_EN
    ,
    output logic [CPACK_CNT_W-1:0]     push_count_o,
    output logic [CPACK_CNT_W-1:0]     wrap_count_o
`endif
);

    localparam int unsigned IDX_W = $clog2(WORDS);

    logic [WIDTH-1:0] entry_q [WORDS];
    logic [WORDS-1:0] valid_q;
    logic [WORDS-1:0] valid_next_c;
    logic [IDX_W-1:0] ptr_q;
    logic             full_q;
    logic [WIDTH-1:0] rd_q;
    logic             push_ok_c;
    logic             wrap_c;

    // A push coinciding with a flush is dropped.
    assign push_ok_c = push_i & ~flush_i;
    assign wrap_c    = push_ok_c & (ptr_q == IDX_W'(WORDS - 1));

    always_comb begin
        valid_next_c = valid_q;
        if (push_ok_c) begin
            valid_next_c[ptr_q] = 1'b1;
        end
    end

    // Read port samples the pre-write contents, giving read-before-write on index collision.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            for (int k = 0; k < int'(WORDS); k++) begin
                entry_q[k] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            rd_q    <= entry_q[rd_idx_i];
            valid_q <= valid_next_c;
            full_q  <= &valid_next_c;
            if (push_ok_c) begin
                entry_q[ptr_q] <= push_word_i;
                ptr_q          <= ptr_q + IDX_W'(1);
            end
        end
    end

    for (genvar g = 0; g < int'(WORDS); g++) begin : g_flat
        assign dictionary_o[g*WIDTH +: WIDTH] = entry_q[g];
    end

    assign valid_mask_o = valid_q;
    assign wr_ptr_o     = ptr_q;
    assign full_o       = full_q;
    assign rd_word_o    = rd_q;

`ifdef CPACK_DICT_STATS_EN
    cpack_sat_counter #(.W(CPACK_CNT_W)) u_push_count (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .inc   (push_ok_c),
        .count (push_count_o)
    );

    cpack_sat_counter #(.W(CPACK_CNT_W)) u_wrap_count (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .inc   (wrap_c),
        .count (wrap_count_o)
    );
`endif

endmodule

// File: tb/tb_cpack_dictionary.sv
// Directed bench for cpack_dictionary with a reference model and a read-port scoreboard.
module tb_cpack_dictionary;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush_i;
    logic            push_i;
    logic [W-1:0]    push_word_i;
    logic [IW-1:0]   rd_idx_i;
    logic [N*W-1:0]  dictionary_o;
    logic [N-1:0]    valid_mask_o;
    logic [IW-1:0]   wr_ptr_o;
    logic            full_o;
    logic [W-1:0]    rd_word_o;
`ifdef CPACK_DICT_STATS_EN
    logic [15:0]     push_count_o;
    logic [15:0]     wrap_count_o;
`endif

    cpack_dictionary dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .push_i       (push_i),
        .push_word_i  (push_word_i),
        .rd_idx_i     (rd_idx_i),
        .dictionary_o (dictionary_o),
        .valid_mask_o (valid_mask_o),
        .wr_ptr_o     (wr_ptr_o),
        .full_o       (full_o),
        .rd_word_o    (rd_word_o)
`ifdef CPACK_DICT_STATS_EN
        ,
        .push_count_o (push_count_o),
        .wrap_count_o (wrap_count_o)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0]  m_ent [N];
    logic [N-1:0]  m_valid;
    logic [IW-1:0] m_ptr;
    logic          m_full;
    int            m_push;
    int            m_wrap;
    logic [W-1:0]  rdq [$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] model_flat();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = m_ent[k];
        return f;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) m_ent[k] = '0;
        m_valid = '0;
        m_ptr   = '0;
        m_full  = 1'b0;
        m_push  = 0;
        m_wrap  = 0;
    endtask

    // Compare all outputs against the model and pop the expected read word.
    task automatic check_all();
        logic [W-1:0] exp_rd;
        if (rdq.size() == 0) begin
            chk("rdq_empty", 512'(1), 512'(0));
        end else begin
            exp_rd = rdq.pop_front();
            chk("rd_word", 512'(rd_word_o), 512'(exp_rd));
        end
        chk("dictionary", 512'(dictionary_o), 512'(model_flat()));
        chk("valid_mask", 512'(valid_mask_o), 512'(m_valid));
        chk("wr_ptr",     512'(wr_ptr_o),     512'(m_ptr));
        chk("full",       512'(full_o),       512'(m_full));
`ifdef CPACK_DICT_STATS_EN
        chk("push_count", 512'(push_count_o), 512'(m_push));
        chk("wrap_count", 512'(wrap_count_o), 512'(m_wrap));
`endif
    endtask

    task automatic step(input logic r, input logic f, input logic p,
                        input logic [W-1:0] w, input logic [IW-1:0] idx);
        reset       = r;
        flush_i     = f;
        push_i      = p;
        push_word_i = w;
        rd_idx_i    = idx;
        if (r || f) rdq.push_back('0);
        else        rdq.push_back(m_ent[idx]);
        if (r || f) begin
            model_clear();
        end else if (p) begin
            if (m_ptr == 4'd15 && m_wrap < 65535) m_wrap++;
            if (m_push < 65535) m_push++;
            m_ent[m_ptr]   = w;
            m_valid[m_ptr] = 1'b1;
            m_ptr          = m_ptr + 4'd1;
            m_full         = &m_valid;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [N*W-1:0] pat;
        logic [W-1:0]   w5;
        model_clear();
        reset = 1'b1; flush_i = 1'b0; push_i = 1'b0; push_word_i = '0; rd_idx_i = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'h0, 4'd0);
        chk("reset_dict",  512'(dictionary_o), 512'(0));
        chk("reset_valid", 512'(valid_mask_o), 512'(0));
        chk("reset_ptr",   512'(wr_ptr_o),     512'(0));
        chk("reset_full",  512'(full_o),       512'(0));

        // Fill with byte-indexed words
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] wd;
            wd = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            step(1'b0, 1'b0, 1'b1, wd, 4'(i));
        end
        for (int b = 0; b < 64; b++) pat[b*8 +: 8] = 8'(b);
        chk("fill_dict",  512'(dictionary_o), 512'(pat));
        chk("fill_valid", 512'(valid_mask_o), 512'(16'hFFFF));
        chk("fill_full",  512'(full_o),       512'(1));
        chk("fill_ptr",   512'(wr_ptr_o),     512'(0));

        // 17th push overwrites the oldest entry
        step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'd0);
        pat[31:0] = 32'hDEADBEEF;
        chk("wrap_dict", 512'(dictionary_o), 512'(pat));
        chk("wrap_ptr",  512'(wr_ptr_o),     512'(1));
        chk("wrap_full", 512'(full_o),       512'(1));
`ifdef CPACK_DICT_STATS_EN
        chk("wrap_cnt1", 512'(wrap_count_o), 512'(1));
`endif

        // Read-before-write at index 3
        step(1'b0, 1'b0, 1'b1, 32'h11111111, 4'd5);
        step(1'b0, 1'b0, 1'b1, 32'h22222222, 4'd0);
        step(1'b0, 1'b0, 1'b1, 32'hAAAA5555, 4'd3);
        chk("rbw_old", 512'(rd_word_o), 512'(32'h0F0E0D0C));
        step(1'b0, 1'b0, 1'b0, 32'h0, 4'd3);
        chk("rbw_new", 512'(rd_word_o), 512'(32'hAAAA5555));

        // Flush with a simultaneous push after 5 pushes
        step(1'b0, 1'b1, 1'b0, 32'h0, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'hC0DE0000 | 32'(i), 4'(i));
        step(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 4'd2);
        chk("flush_dict",  512'(dictionary_o), 512'(0));
        chk("flush_valid", 512'(valid_mask_o), 512'(0));
        chk("flush_ptr",   512'(wr_ptr_o),     512'(0));
        chk("flush_rd",    512'(rd_word_o),    512'(0));
`ifdef CPACK_DICT_STATS_EN
        chk("flush_pcnt",  512'(push_count_o), 512'(0));
`endif

        // Reset in the middle of back-to-back pushes
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h5A000000 | 32'(i), 4'(i));
        step(1'b1, 1'b0, 1'b1, 32'h5A000004, 4'd1);
        chk("midrst_dict",  512'(dictionary_o), 512'(0));
        chk("midrst_valid", 512'(valid_mask_o), 512'(0));
        chk("midrst_ptr",   512'(wr_ptr_o),     512'(0));
        chk("midrst_rd",    512'(rd_word_o),    512'(0));
        w5 = 32'h5A000005;
        for (int i = 5; i < 8; i++) step(1'b0, 1'b0, 1'b1, 32'h5A000000 | 32'(i), 4'(i - 5));
        chk("resume_e0",  512'(dictionary_o[31:0]), 512'(w5));
        chk("resume_ptr", 512'(wr_ptr_o),           512'(3));

        // Random-word pushes interleaved with random reads
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));

`ifdef CPACK_DICT_STATS_EN
        // Counter saturation
        step(1'b0, 1'b1, 1'b0, 32'h0, 4'd0);
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, 1'b1, $urandom, 4'(i));
        chk("sat_push", 512'(push_count_o), 512'(16'hFFFF));
        chk("sat_wrap", 512'(wrap_count_o), 512'(4375));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
